// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse period meter.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_LOCKED
  } meter_state_t;

  // All-ones value of a w-bit counter: the saturation point of the period counter.
  function automatic int unsigned sat_value(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector for a clk-synchronous input; the history bit resets high
// so an input already high when reset releases is not seen as an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_sig,
  output logic rise
);

  logic in_d;

  always_ff @(posedge clk) begin
    if (!reset) in_d <= 1'b1;
    else        in_d <= in_sig;
  end

  assign rise = in_sig & ~in_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle period of a synchronous pulse train, declaring lock after
// LOCK_COUNT consecutive equal periods and flagging late edges and counter saturation.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sig,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_value(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LC_M    = 4'(LOCK_COUNT);

  meter_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       match, match_n, match_inc;
  logic [CNT_W-1:0] period_n;
  logic             valid_n, locked_n, overflow_n;
  logic             rise;

  rise_detect u_rise (
    .clk    (clk),
    .reset  (reset),
    .in_sig (in_sig),
    .rise   (rise)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    match_n    = match;
    period_n   = period;
    valid_n    = 1'b0;
    locked_n   = locked;
    overflow_n = overflow;
    match_inc  = (match >= LC_M) ? LC_M : match + 4'd1;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rise) begin
          cnt_n   = CNT_ONE;
          state_n = S_MEASURE;
        end
      end

      S_MEASURE, S_LOCKED: begin
        if (rise) begin
          cnt_n = CNT_ONE;
          if (overflow) begin
            // Edge ends a saturated interval: restart counting without a measurement.
            overflow_n = 1'b0;
            match_n    = '0;
            locked_n   = 1'b0;
            state_n    = S_MEASURE;
          end else begin
            period_n = cnt;
            valid_n  = 1'b1;
            if (cnt == period && match != '0) match_n = match_inc;
            else                              match_n = 4'd1;
            if (match_n == LC_M) begin
              state_n  = S_LOCKED;
              locked_n = 1'b1;
            end else begin
              state_n  = S_MEASURE;
              locked_n = 1'b0;
            end
          end
        end else begin
          if (cnt != CNT_SAT) cnt_n = cnt + CNT_ONE;
          // Expected edge did not arrive on time: drop lock but keep counting.
          if (state == S_LOCKED && cnt == period) begin
            locked_n = 1'b0;
            match_n  = '0;
            state_n  = S_MEASURE;
          end
          if (cnt_n == CNT_SAT) begin
            overflow_n = 1'b1;
            locked_n   = 1'b0;
            match_n    = '0;
            state_n    = S_MEASURE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      match    <= '0;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      match    <= match_n;
      period   <= period_n;
      valid    <= valid_n;
      locked   <= locked_n;
      overflow <= overflow_n;
    end
  end

endmodule
